// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with valid/ready handshakes on both sides.
// Most opcodes finish in one cycle. Divide runs a bit-serial restoring
// divider for WIDTH cycles. The result is held while the consumer stalls.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Div_Err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   div_b_r;
  logic [WIDTH-1:0]   alu_out_r;
  logic               carry_r;
  logic               zero_r;
  logic               div_err_r;
  logic               out_valid_r;

  logic               accept_s;
  logic               is_div_s;
  logic               b_zero_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_s;
  logic               carry_s;
  logic               derr_s;
  logic [WIDTH:0]     rem_shift_s;
  logic [WIDTH:0]     rem_sub_s;
  logic [WIDTH-1:0]   rem_nxt_s;
  logic [WIDTH-1:0]   quo_nxt_s;

  // A stalled result blocks new work; a consumed one frees the slot in the same cycle.
  assign in_ready  = (state_r == ST_IDLE) || ((state_r == ST_OUT) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign is_div_s  = (ALU_Sel == 4'b0011);
  assign b_zero_s  = (B == {WIDTH{1'b0}});
  assign sum_s     = {1'b0, A} + {1'b0, B};
  assign prod_s    = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  assign out_valid = out_valid_r;
  assign ALU_Out   = alu_out_r;
  assign CarryOut  = carry_r;
  assign Zero      = zero_r;
  assign Div_Err   = div_err_r;

  // Single-cycle result. The div entry is only used for the divide-by-zero case.
  always_comb begin
    res_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    derr_s  = 1'b0;
    case (ALU_Sel)
      4'b0000: begin res_s = sum_s[WIDTH-1:0]; carry_s = sum_s[WIDTH]; end
      4'b0001: begin res_s = A - B; carry_s = (A < B); end
      4'b0010: begin res_s = prod_s[WIDTH-1:0]; carry_s = |prod_s[2*WIDTH-1:WIDTH]; end
      4'b0011: begin res_s = {WIDTH{1'b1}}; derr_s = 1'b1; end
      4'b0100: begin res_s = {A[WIDTH-2:0], 1'b0}; carry_s = A[WIDTH-1]; end
      4'b0101: begin res_s = {1'b0, A[WIDTH-1:1]}; carry_s = A[0]; end
      4'b0110: res_s = {A[WIDTH-2:0], A[WIDTH-1]};
      4'b0111: res_s = {A[0], A[WIDTH-1:1]};
      4'b1000: res_s = A & B;
      4'b1001: res_s = A | B;
      4'b1010: res_s = A ^ B;
      4'b1011: res_s = ~(A | B);
      4'b1100: res_s = ~(A & B);
      4'b1101: res_s = ~(A ^ B);
      4'b1110: res_s = {{(WIDTH-1){1'b0}}, (A > B)};
      4'b1111: res_s = {{(WIDTH-1){1'b0}}, (A == B)};
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // One restoring-division step. The remainder stays below the divisor, so a
  // set top bit after the trial subtract means the divisor did not fit.
  always_comb begin
    rem_shift_s = {rem_r, quo_r[WIDTH-1]};
    rem_sub_s   = rem_shift_s - {1'b0, div_b_r};
    if (rem_sub_s[WIDTH]) begin
      rem_nxt_s = rem_shift_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt_s = rem_sub_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM with the divider datapath and the registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      div_b_r     <= {WIDTH{1'b0}};
      alu_out_r   <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      div_err_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_OUT: begin
          if (accept_s) begin
            if (is_div_s && !b_zero_s) begin
              state_r     <= ST_DIV;
              out_valid_r <= 1'b0;
              quo_r       <= A;
              rem_r       <= {WIDTH{1'b0}};
              div_b_r     <= B;
              cnt_r       <= {CNT_W{1'b0}};
            end else begin
              state_r     <= ST_OUT;
              out_valid_r <= 1'b1;
              alu_out_r   <= res_s;
              carry_r     <= carry_s;
              zero_r      <= (res_s == {WIDTH{1'b0}});
              div_err_r   <= derr_s;
            end
          end else if ((state_r == ST_OUT) && out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end else begin
            state_r     <= state_r;
          end
        end
        ST_DIV: begin
          rem_r <= rem_nxt_s;
          quo_r <= quo_nxt_s;
          if (cnt_r == CNT_LAST) begin
            state_r     <= ST_OUT;
            out_valid_r <= 1'b1;
            alu_out_r   <= quo_nxt_s;
            carry_r     <= 1'b0;
            zero_r      <= (quo_nxt_s == {WIDTH{1'b0}});
            div_err_r   <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (WIDTH=8). It runs directed scenarios first, then
// a back-to-back burst and a random phase with consumer backpressure.
// Expected results go into a queue at acceptance and are compared when the
// result is consumed.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = 8'h00;
  logic [W-1:0] b = 8'h00;
  logic [3:0]   alu_sel = 4'h0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] alu_out;
  logic         carry_out;
  logic         zero;
  logic         div_err;

  int errs   = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       e;
  } exp_t;

  exp_t sbq[$];
  exp_t got_v;

  alu_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
    .ALU_Sel  (alu_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALU_Out  (alu_out),
    .CarryOut (carry_out),
    .Zero     (zero),
    .Div_Err  (div_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one request, written from the opcode table.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    exp_t       m;
    logic [8:0] s;
    logic [15:0] p;
    m = '0;
    s = {1'b0, x} + {1'b0, y};
    p = {8'h00, x} * {8'h00, y};
    case (op)
      4'd0:  begin m.res = s[7:0]; m.c = s[8]; end
      4'd1:  begin m.res = x - y; m.c = (x < y); end
      4'd2:  begin m.res = p[7:0]; m.c = (p[15:8] != 8'h00); end
      4'd3:  begin
               if (y == 8'h00) begin m.res = 8'hFF; m.e = 1'b1; end
               else m.res = x / y;
             end
      4'd4:  begin m.res = x << 1; m.c = x[7]; end
      4'd5:  begin m.res = x >> 1; m.c = x[0]; end
      4'd6:  m.res = {x[6:0], x[7]};
      4'd7:  m.res = {x[0], x[7:1]};
      4'd8:  m.res = x & y;
      4'd9:  m.res = x | y;
      4'd10: m.res = x ^ y;
      4'd11: m.res = ~(x | y);
      4'd12: m.res = ~(x & y);
      4'd13: m.res = ~(x ^ y);
      4'd14: m.res = (x > y) ? 8'd1 : 8'd0;
      default: m.res = (x == y) ? 8'd1 : 8'd0;
    endcase
    m.z = (m.res == 8'h00);
    return m;
  endfunction

  // Scoreboard: push at acceptance, pop and compare at consumption.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_pending", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          got_v = sbq.pop_front();
          check("sb_out",   32'(alu_out),   32'(got_v.res));
          check("sb_carry", 32'(carry_out), 32'(got_v.c));
          check("sb_zero",  32'(zero),      32'(got_v.z));
          check("sb_derr",  32'(div_err),   32'(got_v.e));
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(alu_sel, a, b));
    end
  end

  // Present a request and hold it until accepted. With bp set, out_ready is re-randomised each cycle.
  task automatic send(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y, input logic bp);
    int   n;
    logic acc;
    @(posedge clk); #1;
    alu_sel = op; a = x; b = y; in_valid = 1'b1;
    if (bp) out_ready = 1'($urandom_range(0, 1));
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else begin
        @(posedge clk); #1;
        if (bp) out_ready = 1'($urandom_range(0, 1));
        n++;
      end
    end
    check("send_accepted", 32'(acc), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] op_v;
    logic [7:0] x_v;
    logic [7:0] y_v;
    int         n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out",       32'(alu_out),   32'd0);
    check("rst_carry",     32'(carry_out), 32'd0);
    check("rst_zero",      32'(zero),      32'd0);
    check("rst_derr",      32'(div_err),   32'd0);

    // shl1 of 0x81: result one cycle after acceptance
    send(4'b0100, 8'h81, 8'h00, 1'b0);
    @(negedge clk);
    check("shl_valid", 32'(out_valid), 32'd1);
    check("shl_out",   32'(alu_out),   32'h02);
    check("shl_carry", 32'(carry_out), 32'd1);
    check("shl_zero",  32'(zero),      32'd0);

    // add wraps to zero with carry
    send(4'b0000, 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    check("add_out",   32'(alu_out),   32'h00);
    check("add_carry", 32'(carry_out), 32'd1);
    check("add_zero",  32'(zero),      32'd1);

    // 200/7: busy for 8 cycles, result on cycle 9; inputs during busy are ignored
    send(4'b0011, 8'd200, 8'd7, 1'b0);
    alu_sel = 4'b0000; a = 8'h01; b = 8'h01; in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("div_busy_ready", 32'(in_ready),  32'd0);
      check("div_busy_valid", 32'(out_valid), 32'd0);
      if (i == 8) in_valid = 1'b0;
    end
    @(negedge clk);
    check("div_valid", 32'(out_valid), 32'd1);
    check("div_out",   32'(alu_out),   32'h1C);
    check("div_derr",  32'(div_err),   32'd0);

    // divide by zero finishes in one cycle
    send(4'b0011, 8'd5, 8'd0, 1'b0);
    @(negedge clk);
    check("dz_valid", 32'(out_valid), 32'd1);
    check("dz_out",   32'(alu_out),   32'hFF);
    check("dz_derr",  32'(div_err),   32'd1);
    check("dz_carry", 32'(carry_out), 32'd0);

    // two subtracts back to back while the consumer stalls for 3 cycles
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; alu_sel = 4'b0001; a = 8'd3; b = 8'd5;
    @(posedge clk); #1;
    a = 8'd9; b = 8'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_out",   32'(alu_out),   32'hFE);
      check("stall_carry", 32'(carry_out), 32'd1);
      check("stall_ready", 32'(in_ready),  32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("sub2_out",   32'(alu_out),   32'h05);
    check("sub2_carry", 32'(carry_out), 32'd0);

    // reset on the 4th cycle of a divide aborts it
    send(4'b0011, 8'd100, 8'd3, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_busy", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready),  32'd1);
    check("abort_out",   32'(alu_out),   32'd0);
    check("abort_carry", 32'(carry_out), 32'd0);
    check("abort_zero",  32'(zero),      32'd0);
    check("abort_derr",  32'(div_err),   32'd0);

    // reset wins over a simultaneous handshake
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; alu_sel = 4'b0000; a = 8'h10; b = 8'h20;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rstprio_valid", 32'(out_valid), 32'd0);

    // one non-div request per cycle with the consumer always ready
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      op_v = 4'($urandom_range(0, 15));
      if (op_v == 4'd3) op_v = 4'd15;
      alu_sel = op_v; a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
      @(negedge clk);
      check("burst_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // random opcodes and operands with random backpressure
    for (int k = 0; k < 40; k++) begin
      op_v = 4'($urandom_range(0, 15));
      x_v  = 8'($urandom);
      y_v  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      send(op_v, x_v, y_v, 1'b1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
